// File: rtl/rv_decode_pkg.sv
// Shared encodings for the RV32I-subset decode stage: opcodes, ALUOp,
// ALU control, immediate-source and result-source selectors.
package rv_decode_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD  = 2'b00,
    ALUOP_SUB  = 2'b01,
    ALUOP_FUNC = 2'b10
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

endpackage

// File: rtl/rv_regfile.sv
// 32 x WORD_SIZE register file: two combinational read ports, one write port,
// x0 hardwired to zero, and same-cycle write-through to the read ports.
module rv_regfile #(
  parameter int WORD_SIZE = rv_decode_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           a1,
  input  logic [4:0]           a2,
  input  logic [4:0]           a3,
  input  logic                 we3,
  input  logic [WORD_SIZE-1:0] wd3,
  output logic [WORD_SIZE-1:0] rd1,
  output logic [WORD_SIZE-1:0] rd2
);

  logic [WORD_SIZE-1:0] regs_r [32];
  logic                 fwd_en_s;

  // Reset clears every entry; writes to x0 are dropped so it stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= {WORD_SIZE{1'b0}};
      end
    end else if (we3 && (a3 != 5'd0)) begin
      regs_r[a3] <= wd3;
    end
  end

  // Reset also suppresses forwarding, since the write it would mirror is dropped.
  assign fwd_en_s = !rst && we3 && (a3 != 5'd0);

  // Read port 1 with write-through.
  always_comb begin
    rd1 = {WORD_SIZE{1'b0}};
    if (a1 == 5'd0) begin
      rd1 = {WORD_SIZE{1'b0}};
    end else if (fwd_en_s && (a3 == a1)) begin
      rd1 = wd3;
    end else begin
      rd1 = regs_r[a1];
    end
  end

  // Read port 2 with write-through.
  always_comb begin
    rd2 = {WORD_SIZE{1'b0}};
    if (a2 == 5'd0) begin
      rd2 = {WORD_SIZE{1'b0}};
    end else if (fwd_en_s && (a3 == a2)) begin
      rd2 = wd3;
    end else begin
      rd2 = regs_r[a2];
    end
  end

endmodule

// File: rtl/rv_decode_unit.sv
// Decode-stage block: main/ALU decoders, immediate extender and register file.
// Everything except the register array is combinational from instr.
module rv_decode_unit #(
  parameter int WORD_SIZE = rv_decode_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic [4:0]           rd_w,
  input  logic                 reg_write_w,
  input  logic [WORD_SIZE-1:0] result_w,
  output logic [WORD_SIZE-1:0] rd1,
  output logic [WORD_SIZE-1:0] rd2,
  output logic [WORD_SIZE-1:0] imm_ext,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic                 reg_write,
  output logic [1:0]           result_src,
  output logic                 mem_write,
  output logic                 jump,
  output logic                 branch,
  output logic                 alu_src,
  output logic [2:0]           alu_control,
  output logic [1:0]           imm_src,
  output logic                 byte_address,
  output logic                 read_enable
);

  import rv_decode_pkg::*;

  logic [6:0]  op_s;
  logic [2:0]  f3_s;
  logic        f7b5_s;
  logic        op5_s;
  alu_op_e     alu_op_s;
  alu_ctrl_e   alu_ctrl_s;
  imm_src_e    imm_src_s;
  result_src_e result_src_s;

  assign op_s   = instr[6:0];
  assign f3_s   = instr[14:12];
  assign f7b5_s = instr[30];
  assign op5_s  = instr[5];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  // Main decoder; unknown opcodes leave every control at zero.
  always_comb begin
    reg_write    = 1'b0;
    imm_src_s    = IMM_I;
    alu_src      = 1'b0;
    mem_write    = 1'b0;
    result_src_s = RES_ALU;
    branch       = 1'b0;
    alu_op_s     = ALUOP_ADD;
    jump         = 1'b0;
    read_enable  = 1'b0;
    case (op_s)
      OP_LOAD: begin
        reg_write    = 1'b1;
        alu_src      = 1'b1;
        result_src_s = RES_MEM;
        read_enable  = 1'b1;
      end
      OP_STORE: begin
        imm_src_s = IMM_S;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_RTYPE: begin
        reg_write = 1'b1;
        alu_op_s  = ALUOP_FUNC;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op_s  = ALUOP_FUNC;
      end
      OP_BEQ: begin
        imm_src_s = IMM_B;
        branch    = 1'b1;
        alu_op_s  = ALUOP_SUB;
      end
      OP_JAL: begin
        reg_write    = 1'b1;
        imm_src_s    = IMM_J;
        result_src_s = RES_PC4;
        jump         = 1'b1;
      end
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

  // Byte access only for lb/sb; every other funct3 is treated as a word access.
  always_comb begin
    byte_address = 1'b0;
    if (((op_s == OP_LOAD) || (op_s == OP_STORE)) && (f3_s == 3'b000)) begin
      byte_address = 1'b1;
    end else begin
      byte_address = 1'b0;
    end
  end

  // ALU decoder; sub needs op5 so that addi with instr[30] set stays an add.
  always_comb begin
    alu_ctrl_s = ALU_ADD;
    case (alu_op_s)
      ALUOP_ADD: alu_ctrl_s = ALU_ADD;
      ALUOP_SUB: alu_ctrl_s = ALU_SUB;
      ALUOP_FUNC: begin
        case (f3_s)
          3'b000: begin
            if (op5_s && f7b5_s) begin
              alu_ctrl_s = ALU_SUB;
            end else begin
              alu_ctrl_s = ALU_ADD;
            end
          end
          3'b010:  alu_ctrl_s = ALU_SLT;
          3'b110:  alu_ctrl_s = ALU_OR;
          3'b111:  alu_ctrl_s = ALU_AND;
          default: alu_ctrl_s = ALU_ADD;
        endcase
      end
      default: alu_ctrl_s = ALU_ADD;
    endcase
  end

  // Immediate extender, sign taken from instr[31] in every format.
  always_comb begin
    imm_ext = {WORD_SIZE{1'b0}};
    case (imm_src_s)
      IMM_I: imm_ext = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm_ext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm_ext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_ext = {WORD_SIZE{1'b0}};
    endcase
  end

  assign imm_src     = imm_src_s;
  assign result_src  = result_src_s;
  assign alu_control = alu_ctrl_s;

  rv_regfile #(
    .WORD_SIZE(WORD_SIZE)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .a1  (rs1),
    .a2  (rs2),
    .a3  (rd_w),
    .we3 (reg_write_w),
    .wd3 (result_w),
    .rd1 (rd1),
    .rd2 (rd2)
  );

endmodule

// File: tb/tb_rv_decode_unit.sv
// Scoreboard bench for rv_decode_unit: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares them.
module tb_rv_decode_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [4:0]  rd_w;
  logic        reg_write_w;
  logic [31:0] result_w;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] imm_ext;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        reg_write;
  logic [1:0]  result_src;
  logic        mem_write;
  logic        jump;
  logic        branch;
  logic        alu_src;
  logic [2:0]  alu_control;
  logic [1:0]  imm_src;
  logic        byte_address;
  logic        read_enable;

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [14:0] fld;
    logic [13:0] ctl;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;

  rv_decode_unit #(.WORD_SIZE(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .rd_w         (rd_w),
    .reg_write_w  (reg_write_w),
    .result_w     (result_w),
    .rd1          (rd1),
    .rd2          (rd2),
    .imm_ext      (imm_ext),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .reg_write    (reg_write),
    .result_src   (result_src),
    .mem_write    (mem_write),
    .jump         (jump),
    .branch       (branch),
    .alu_src      (alu_src),
    .alu_control  (alu_control),
    .imm_src      (imm_src),
    .byte_address (byte_address),
    .read_enable  (read_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {reg_write, result_src, mem_write, jump, branch, alu_src, alu_control, imm_src, byte_address, read_enable}
  function automatic logic [13:0] cw(input logic rw, input logic [1:0] rs, input logic mw,
                                     input logic j, input logic b, input logic as,
                                     input logic [2:0] ac, input logic [1:0] is,
                                     input logic ba, input logic re);
    return {rw, rs, mw, j, b, as, ac, is, ba, re};
  endfunction

  function automatic exp_t ex(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                              input logic [13:0] c);
    exp_t e;
    e.rd1 = r1;
    e.rd2 = r2;
    e.imm = im;
    e.fld = {s1, s2, d};
    e.ctl = c;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exv, $time);
    end
  endtask

  task automatic apply(input logic [31:0] ins, input logic [4:0] wrd, input logic wwe,
                       input logic [31:0] wres, input exp_t e);
    @(posedge clk);
    #1;
    instr       = ins;
    rd_w        = wrd;
    reg_write_w = wwe;
    result_w    = wres;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every pending expectation at the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      chk("rd1", rd1, cur.rd1);
      chk("rd2", rd2, cur.rd2);
      chk("imm_ext", imm_ext, cur.imm);
      chk("fields", {17'd0, rs1, rs2, rd}, {17'd0, cur.fld});
      chk("controls", {18'd0, reg_write, result_src, mem_write, jump, branch, alu_src,
                       alu_control, imm_src, byte_address, read_enable}, {18'd0, cur.ctl});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  localparam logic [13:0] C0 = 14'd0;

  initial begin
    rst         = 1'b1;
    instr       = 32'd0;
    rd_w        = 5'd0;
    reg_write_w = 1'b0;
    result_w    = 32'd0;
    #12;
    rst = 1'b0;

    // Reset state, register writes, x0 and write-through.
    apply(32'h00728000, 5'd0, 1'b0, 32'd0,         ex(32'd0, 32'd0, 32'd7, 5'd5, 5'd7, 5'd0, C0));
    apply(32'h00000000, 5'd5, 1'b1, 32'hDEADBEEF,  ex(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, C0));
    apply(32'h00028000, 5'd0, 1'b0, 32'd0,         ex(32'hDEADBEEF, 32'd0, 32'd0, 5'd5, 5'd0, 5'd0, C0));
    apply(32'h00000000, 5'd0, 1'b1, 32'h12345678,  ex(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, C0));
    apply(32'h00000000, 5'd0, 1'b0, 32'd0,         ex(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, C0));
    apply(32'h00700000, 5'd7, 1'b1, 32'hCAFEF00D,  ex(32'd0, 32'hCAFEF00D, 32'd7, 5'd0, 5'd7, 5'd0, C0));
    apply(32'h00700000, 5'd9, 1'b1, 32'h00001000,  ex(32'd0, 32'hCAFEF00D, 32'd7, 5'd0, 5'd7, 5'd0, C0));
    apply(32'h00000000, 5'd6, 1'b1, 32'h0000ABCD,  ex(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, C0));
    apply(32'h00000000, 5'd4, 1'b1, 32'h00000044,  ex(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, C0));

    // Loads and stores, word and byte.
    apply(32'hFFC4A303, 5'd0, 1'b0, 32'd0, ex(32'h00001000, 32'd0, 32'hFFFFFFFC, 5'd9, 5'd28, 5'd6,
          cw(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0, 1'b1)));
    apply(32'hFFC48303, 5'd0, 1'b0, 32'd0, ex(32'h00001000, 32'd0, 32'hFFFFFFFC, 5'd9, 5'd28, 5'd6,
          cw(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b1, 1'b1)));
    apply(32'h0064A423, 5'd0, 1'b0, 32'd0, ex(32'h00001000, 32'h0000ABCD, 32'd8, 5'd9, 5'd6, 5'd8,
          cw(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 2'b01, 1'b0, 1'b0)));
    apply(32'h00648423, 5'd0, 1'b0, 32'd0, ex(32'h00001000, 32'h0000ABCD, 32'd8, 5'd9, 5'd6, 5'd8,
          cw(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 2'b01, 1'b1, 1'b0)));

    // Branch, ALU ops, jump, illegal opcode.
    apply(32'hFE420CE3, 5'd0, 1'b0, 32'd0, ex(32'h44, 32'h44, 32'hFFFFFFF8, 5'd4, 5'd4, 5'd25,
          cw(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 2'b10, 1'b0, 1'b0)));
    apply(32'h40000033, 5'd0, 1'b0, 32'd0, ex(32'd0, 32'd0, 32'h400, 5'd0, 5'd0, 5'd0,
          cw(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 2'b00, 1'b0, 1'b0)));
    apply(32'h40007033, 5'd0, 1'b0, 32'd0, ex(32'd0, 32'd0, 32'h400, 5'd0, 5'd0, 5'd0,
          cw(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 2'b00, 1'b0, 1'b0)));
    apply(32'h40000013, 5'd0, 1'b0, 32'd0, ex(32'd0, 32'd0, 32'h400, 5'd0, 5'd0, 5'd0,
          cw(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 2'b00, 1'b0, 1'b0)));
    apply(32'h00002033, 5'd0, 1'b0, 32'd0, ex(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0,
          cw(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 2'b00, 1'b0, 1'b0)));
    apply(32'h00006033, 5'd0, 1'b0, 32'd0, ex(32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0,
          cw(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 2'b00, 1'b0, 1'b0)));
    apply(32'h008000EF, 5'd0, 1'b0, 32'd0, ex(32'd0, 32'd0, 32'd8, 5'd0, 5'd8, 5'd1,
          cw(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 2'b11, 1'b0, 1'b0)));
    apply(32'hFFFFFFFF, 5'd0, 1'b0, 32'd0, ex(32'd0, 32'd0, 32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, C0));

    // Mid-cycle reset: x5/x7 read zero before any clock edge, then sweep all indices.
    apply(32'h00728000, 5'd0, 1'b0, 32'd0, ex(32'd0, 32'd0, 32'd7, 5'd5, 5'd7, 5'd0, C0));
    #2;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apply((32'(i) << 15) | (32'(i + 16) << 20), 5'd0, 1'b0, 32'd0,
            ex(32'd0, 32'd0, 32'(i + 16), 5'(i), 5'(i + 16), 5'd0, C0));
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    apply(32'h0064A423, 5'd0, 1'b0, 32'd0, ex(32'd0, 32'd0, 32'd8, 5'd9, 5'd6, 5'd8,
          cw(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 2'b01, 1'b0, 1'b0)));

    for (int k = 0; k < 20 && sb_q.size() > 0; k++) begin
      @(posedge clk);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_decode_unit.md
Name: rv_decode_unit

Overview:
Combinational RV32I-subset instruction decoder, immediate extender and 32x32 register file, packaged as one block. It sits in the decode stage of the 5-stage pipeline. It produces the register operands, the extended immediate, the field indices and all control signals that the decode/execute pipeline register captures. Register writeback from the W stage enters through the write port.

Parameters:
WORD_SIZE, 32, data/instruction width (only 32 supported)

Ports:
clk  in  1  clock; register-file write edge (rising)
rst  in  1  reset, asynchronous, active-high; clears all registers
instr  in  32  instruction in decode
rd_w  in  5  writeback destination index
reg_write_w  in  1  writeback enable
result_w  in  32  writeback data
rd1  out  32  value of x[instr[19:15]]
rd2  out  32  value of x[instr[24:20]]
imm_ext  out  32  extended immediate
rs1, rs2, rd  out  5 each  instr[19:15], instr[24:20], instr[11:7]
reg_write  out  1  instruction writes rd
result_src  out  2  00 ALU, 01 memory, 10 PC+4
mem_write  out  1  store
jump  out  1  jal
branch  out  1  beq
alu_src  out  1  ALU B operand: 0 register, 1 immediate
alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  out  2  00 I, 01 S, 10 B, 11 J
byte_address  out  1  byte access (lb/sb)
read_enable  out  1  load

Behaviour:
- Clock is clk. Reset is rst, asynchronous and active-high.
- Register file:
  - 32 x 32-bit registers. Asynchronous reset sets all registers to 0.
  - Write on rising clk when reg_write_w=1 and rd_w!=0. Writes to x0 are ignored; x0 always reads 0.
  - Reads are combinational.
  - Write-through: if reg_write_w=1, rd_w!=0 and rd_w equals a read index, that read port returns result_w in the same cycle.
  - If rst is asserted, it overrides any write in the same cycle.
- Main decoder, keyed on op=instr[6:0]. Fields listed are RegWrite, ImmSrc, ALUSrc, MemWrite, ResultSrc, Branch, ALUOp, Jump, ReadEnable:
  - 0000011 load: 1, 00, 1, 0, 01, 0, 00, 0, 1
  - 0100011 store: 0, 01, 1, 1, 00, 0, 00, 0, 0
  - 0110011 R-type: 1, 00, 0, 0, 00, 0, 10, 0, 0
  - 0010011 I-ALU: 1, 00, 1, 0, 00, 0, 10, 0, 0
  - 1100011 beq: 0, 10, 0, 0, 00, 1, 01, 0, 0
  - 1101111 jal: 1, 11, 0, 0, 10, 0, 00, 1, 0
  - Any other opcode: all control outputs 0, including alu_control=000.
- byte_address=1 only for load or store with funct3=000. funct3=010 is a word access. Other funct3 values for load/store give byte_address=0.
- ALU decoder (f3=instr[14:12], f7b5=instr[30], op5=instr[5]):
  - ALUOp 00 gives 000; ALUOp 01 gives 001.
  - ALUOp 10, f3=000: 001 if op5 & f7b5, else 000. So addi is never sub.
  - ALUOp 10: f3=010 gives 101; f3=110 gives 011; f3=111 gives 010; other f3 give 000.
- Extender (sign bit s=instr[31]):
  - I: {20{s}}, instr[31:20]
  - S: {20{s}}, instr[31:25], instr[11:7]
  - B: {20{s}}, instr[7], instr[30:25], instr[11:8], 0
  - J: {12{s}}, instr[19:12], instr[20], instr[30:21], 0
- All decode outputs are purely combinational from instr (zero latency). Only the register array holds state.

Decomposition:
- Shared package rv_decode_pkg holds:
  - opcode constants
  - ALUOp, alu_control, imm_src and result_src encodings
  - WORD_SIZE
- One natural sub-module: rv_regfile (storage, x0 hardwiring, write-through).
- Control and extender logic stay inline.

Test Plan:
- rst pulse mid-cycle, then read all 32 indices -> every read returns 0x00000000, asserted immediately and asynchronously.
- Write 0xDEADBEEF to x5 (reg_write_w=1) -> after the edge, instr with rs1=5 gives rd1=0xDEADBEEF. Write 0x12345678 to x0 -> reads of x0 return 0. Same-cycle write/read of x7 -> rd2 shows result_w before the edge.
- instr=0xFFC4A303 (lw x6,-4(x9)):
  - rs1=9, rd=6, imm_ext=0xFFFFFFFC, alu_src=1
  - result_src=01, reg_write=1, read_enable=1, byte_address=0, alu_control=000
- instr=0x0064A423 (sw x6,8(x9)):
  - imm_ext=0x00000008, mem_write=1, reg_write=0, imm_src=01
  - same instruction with funct3=000 -> byte_address=1
- instr=0xFE420CE3 (beq x4,x4,-8) -> branch=1, alu_control=001, imm_src=10, imm_ext=0xFFFFFFF8, reg_write=0.
- R-type sub (0x40000033 with f3=000) -> alu_control=001; with f3=111 -> 010; instr=0x00000000 (illegal) -> all controls 0.
